multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle MIPS control unit: a registered FSM that sequences each instruction over 3–5 cycles and drives the shared-ALU / unified-memory datapath. It is the next generation of the single-cycle opcode decoder. It adds a memory-ready handshake, a memory timeout with error reporting, illegal-opcode detection and an optional ADDI path. It sits between the instruction register's opcode field and the datapath muxes and enables.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive cycles without `mem_ready` in a memory state before abort. Legal range is ≥2.
- CNT_W, $clog2(MEM_TIMEOUT+1): wait-counter width. Derived; do not override.

Ports (clock and reset first):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous, active-low reset.
- Inputs:
  - op  in  6  opcode from the instruction register.
  - mem_ready  in  1  memory has completed the current read or write this cycle.
- Program-counter and instruction-register control:
  - PCWrite  out  1  unconditional PC load.
  - PCWriteCond  out  1  PC load if the ALU Zero flag is set.
  - IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
  - IRWrite  out  1  instruction register load.
  - PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- Memory control:
  - MemRead  out  1  memory read strobe.
  - MemWrite  out  1  memory write strobe.
- Register-file and ALU control:
  - MemtoReg  out  1  register write data select: 1 = MDR.
  - RegDst  out  1  destination register select: 1 = rd.
  - RegWrite  out  1  register file write enable.
  - ALUSrcA  out  1  ALU A select: 1 = register A.
  - ALUSrcB  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
  - ALUOp  out  2  00 = add, 01 = subtract, 10 = funct field.
- Status:
  - state  out  4  current state, for debug.
  - illegal_op  out  1  one-cycle pulse on an unsupported opcode.
  - mem_err  out  1  one-cycle pulse on a memory timeout.

## Operation
States and their nonzero outputs:
- S_FETCH (0): MemRead, ALUSrcB=01.
  - IRWrite and PCWrite are asserted only in cycles with `mem_ready`=1.
- S_DECODE (1): ALUSrcB=11.
- S_MEMADR (2): ALUSrcA, ALUSrcB=10.
- S_MEMRD (3): MemRead, IorD.
- S_MEMWB (4): RegWrite, MemtoReg.
- S_MEMWR (5): MemWrite, IorD.
- S_EXEC (6): ALUSrcA, ALUOp=10.
- S_ALUWB (7): RegWrite, RegDst.
- S_BRANCH (8): ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01.
- S_JUMP (9): PCWrite, PCSource=10.
- S_ADDIEX (10): ALUSrcA, ALUSrcB=10. Present only with ADDI_EN.
- S_ADDIWB (11): RegWrite. Present only with ADDI_EN.

All outputs not listed for a state are 0.

Transitions:
- S_FETCH → S_DECODE when `mem_ready`=1; otherwise stay.
- S_DECODE goes on the opcode:
  - 000000 → S_EXEC
  - 100011 and 101011 → S_MEMADR
  - 000100 → S_BRANCH
  - 000010 → S_JUMP
  - 001000 → S_ADDIEX (ADDI_EN only)
  - any other opcode → S_FETCH, with `illegal_op`=1 in that S_DECODE cycle.
- S_MEMADR → S_MEMRD for lw, S_MEMWR for sw. The opcode is re-sampled here; the IR is stable.
- S_MEMRD → S_MEMWB on `mem_ready`.
- S_MEMWR → S_FETCH on `mem_ready`.
- S_EXEC → S_ALUWB.
- S_ADDIEX → S_ADDIWB.
- S_ALUWB, S_MEMWB, S_ADDIWB, S_BRANCH and S_JUMP → S_FETCH.
- Undefined state encodings → S_FETCH.

Wait counter:
- Increments each cycle spent in S_FETCH, S_MEMRD or S_MEMWR with `mem_ready`=0.
- Clears on `mem_ready`=1 and on any exit from these states.
- When the count reaches MEM_TIMEOUT-1 and `mem_ready` is still 0:
  - `mem_err` pulses for that cycle.
  - The next state is S_FETCH and the counter clears.
  - A timed-out S_MEMWR does not retry. A timed-out S_FETCH re-fetches the same PC, because PCWrite never asserted.
- `mem_ready` arriving in the same cycle as the timeout wins: normal transition, no `mem_err`.

## Timing
- The state register is updated on the clock edge. Outputs decode combinationally from `state`, and from `mem_ready` for IRWrite/PCWrite.
- Cycles per instruction with zero wait states: lw 5; sw, R-type and addi 4; beq and j 3. Each wait state adds 1 cycle.
- Reset values:
  - `state`=S_FETCH, counter 0, `illegal_op`=0, `mem_err`=0.
  - While `rst_n`=0, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond and RegWrite are forced to 0. The remaining outputs take their S_FETCH values.
- Deassertion of reset takes effect at the first clock edge; the first fetch starts that cycle.
- Reset asserted mid-instruction aborts it immediately, with no write strobe after `rst_n` falls.

## Configuration
- ADDI_EN defined: opcode 001000 runs S_DECODE → S_ADDIEX → S_ADDIWB. S_ADDIWB writes rt (RegDst=0) from ALUOut (MemtoReg=0).
- ADDI_EN undefined: states 10 and 11 are not generated, and 001000 raises `illegal_op` like any other unsupported opcode.

## Structure
- Shared package `mc_pkg`:
  - state enum `mc_state_t` (4 bits, values as above);
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - ALUSrcB and PCSource encodings.
- Sub-module `mc_mem_timer`: the wait counter plus timeout compare. It is parametrised by MEM_TIMEOUT; inputs are `in_mem_state` and `mem_ready`; output is `timeout`.

## Test plan
- lw, `op`=100011, `mem_ready` held at 1 → state sequence 0,1,2,3,4,0 over 5 cycles. RegWrite=1 and MemtoReg=1 only in cycle 5.
- R-type, `op`=000000, with 3 wait cycles in S_FETCH → IRWrite pulses exactly once (cycle 4), then EXEC with ALUOp=10 and ALUWB with RegDst=1. Total 7 cycles.
- sw with `mem_ready` low for the whole S_MEMWR, MEM_TIMEOUT=4 → MemWrite high for 4 cycles, `mem_err` pulse in the 4th, next state S_FETCH. With `mem_ready` rising in that 4th cycle instead: no `mem_err`.
- `op`=111111 → `illegal_op`=1 for exactly one cycle in S_DECODE, back to S_FETCH, no write strobe asserted. Repeat with `op`=001000 for both ADDI_EN builds: 4-cycle addi with RegWrite in S_ADDIWB when defined; `illegal_op` when undefined.
- beq (`op`=000100) and j (`op`=000010) → each takes 3 cycles. S_BRANCH has PCWriteCond=1, PCSource=01, ALUOp=01. S_JUMP has PCWrite=1, PCSource=10.
- Assert `rst_n`=0 in the middle of S_MEMRD → `state`=0 asynchronously and all strobes 0 while reset is held. The first cycle after release has MemRead=1 and counter 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit and its memory-wait timer.
// Holds the state enum, opcodes, ALUOp, ALUSrcB and PCSource encodings.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } mc_state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_mem_timer.sv
// Counts consecutive memory-state cycles without mem_ready; timeout is combinational in the
// cycle the count sits at MEM_TIMEOUT-1 with mem_ready still low. No backpressure of its own.
module mc_mem_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_mem_state,
   input  logic mem_ready,
   output logic timeout
);

   logic [CNT_W-1:0] cnt;

   assign timeout = in_mem_state && !mem_ready && (cnt == CNT_W'(MEM_TIMEOUT - 1));

   // A timeout forces the FSM back to fetch, so the count restarts with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!in_mem_state || mem_ready || timeout) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction, outputs decoded from state (and mem_ready
// for IRWrite/PCWrite); memory states stall on mem_ready with timeout abort. ADDI_EN enables addi.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       IRWrite,
   output logic [1:0] PCSource,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] state,
   output logic       illegal_op,
   output logic       mem_err
);

   mc_state_t state_q, state_d;
   logic      in_mem_state;
   logic      timeout;
   logic      op_known;

   assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

   mc_mem_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_mem_state (in_mem_state),
      .mem_ready    (mem_ready),
      .timeout      (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      op_known = 1'b0;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_known = 1'b1;
`ifdef ADDI_EN
         OP_ADDI:                              op_known = 1'b1;
`endif
         default:                              op_known = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
         S_MEMWR:  state_d = (mem_ready || timeout) ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
`ifdef ADDI_EN
         S_ADDIEX: state_d = S_ADDIWB;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = PCSRC_ALU;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUOp       = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: ALUSrcB = SRCB_IMM_SH;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
`ifdef ADDI_EN
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_ADDIWB: RegWrite = 1'b1;
`endif
         default: ;
      endcase
      // Strobes are held low for the whole reset so an aborted instruction never writes.
      if (!rst_n) begin
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         RegWrite    = 1'b0;
      end
   end

   assign state      = state_q;
   assign illegal_op = rst_n && (state_q == S_DECODE) && !op_known;
   assign mem_err    = rst_n && timeout;

endmodule
